// File: rtl/booth_pp_gen.sv
// -----------------------------------------------------------------------------
// fpu_defs_fmac / booth_pp_gen
//
// Pipelined radix-4 (modified) Booth partial-product generator for the fmac
// datapath. The multiplier B is recoded into 13 Booth digits. Each digit
// selects one of 0, +-A or +-2A. Each selection is shifted by 4^i and fully
// sign-extended to 2*C_MANT+3 bits. Modulo 2^(2*C_MANT+3), the 13 products
// sum to A*B.
//
// Pipeline:
//   S1 holds A, the per-digit {neg, one, two} controls, the tag and a valid bit.
//   S2 holds the 13 generated products, the tag and a valid bit.
//   Both stages use a valid/ready handshake with bubble collapse.
//
// Ports:
//   Clk_CI       in   clock, rising edge
//   Rst_RI       in   synchronous active-high reset (flush + zero data)
//   Flush_SI     in   synchronous kill of all in-flight operations
//   Valid_SI     in   input operands valid
//   Ready_SO     out  block accepts an input this cycle
//   Mant_a_DI    in   multiplicand A, unsigned, C_MANT+1 bits
//   Mant_b_DI    in   multiplier B, unsigned, C_MANT+1 bits
//   Tag_DI       in   opaque tag, returned with the result
//   Valid_SO     out  partial products valid
//   Ready_SI     in   downstream accepts this cycle
//   Pp_index_DO  out  13 partial products, 2*C_MANT+3 bits each
//   Tag_DO       out  tag of the presented operation
// -----------------------------------------------------------------------------
package fpu_defs_fmac;
  localparam int unsigned C_MANT = 23;
endpackage

module booth_pp_gen
  import fpu_defs_fmac::*;
#(
  parameter int TAG_WIDTH = 4
) (
  input  logic                                  Clk_CI,
  input  logic                                  Rst_RI,
  input  logic                                  Flush_SI,
  input  logic                                  Valid_SI,
  output logic                                  Ready_SO,
  input  logic [C_MANT:0]                       Mant_a_DI,
  input  logic [C_MANT:0]                       Mant_b_DI,
  input  logic [TAG_WIDTH-1:0]                  Tag_DI,
  output logic                                  Valid_SO,
  input  logic                                  Ready_SI,
  output logic [12:0][2*C_MANT+2:0]             Pp_index_DO,
  output logic [TAG_WIDTH-1:0]                  Tag_DO
);

  localparam int NDIG = 13;
  localparam int MW   = C_MANT + 1;
  localparam int PPW  = 2 * C_MANT + 3;
  localparam int BXW  = 2 * NDIG + 1;   // zero-extended B plus the implicit b[-1]

  // Stage 1 state
  logic                    r_v1;
  logic [MW-1:0]           r_a1;
  logic [NDIG-1:0]         r_neg1, r_one1, r_two1;
  logic [TAG_WIDTH-1:0]    r_tag1;

  // Stage 2 state
  logic                    r_v2;
  logic [NDIG-1:0][PPW-1:0] r_pp2;
  logic [TAG_WIDTH-1:0]    r_tag2;

  // Combinational signals
  logic                    w_s1_load, w_s2_load;
  logic [BXW-1:0]          w_bx;
  logic [2:0]              w_trip;
  logic [NDIG-1:0]         w_neg, w_one, w_two;
  logic [PPW-1:0]          w_mag;
  logic [NDIG-1:0][PPW-1:0] w_pp;

  // S2 can take new data when it is empty or its content leaves this cycle.
  // S1 can then advance into S2 in the same cycle, so Ready_SO holds even with
  // both stages full, as long as downstream is draining.
  assign w_s2_load = !r_v2 || Ready_SI;
  assign Ready_SO  = !Flush_SI && (!r_v1 || w_s2_load);
  assign w_s1_load = Ready_SO && Valid_SI;

  // Booth recoding of the triplet {b[2i+1], b[2i], b[2i-1]}.
  // neg is suppressed for 111, so that encoding yields a true zero.
  always_comb begin
    // NOTE: every variable written in a combinational block gets a default
    // first. Otherwise a path that skips the assignment infers a latch.
    w_bx   = {{(2*NDIG-MW){1'b0}}, Mant_b_DI, 1'b0};
    w_trip = '0;
    w_neg  = '0;
    w_one  = '0;
    w_two  = '0;
    for (int i = 0; i < NDIG; i++) begin
      w_trip   = w_bx[2*i +: 3];
      w_one[i] = w_trip[1] ^ w_trip[0];
      w_two[i] = (w_trip == 3'b011) || (w_trip == 3'b100);
      w_neg[i] = w_trip[2] && !(w_trip[1] && w_trip[0]);
    end
  end

  // Partial-product generation from the S1 controls.
  // Negation is a full two's complement in PPW bits.
  always_comb begin
    w_mag = '0;
    w_pp  = '0;
    for (int i = 0; i < NDIG; i++) begin
      w_mag = PPW'(r_a1) << (2 * i);
      if (r_two1[i]) begin
        w_mag = w_mag << 1;
      end else if (!r_one1[i]) begin
        w_mag = '0;
      end
      w_pp[i] = r_neg1[i] ? (~w_mag + PPW'(1)) : w_mag;
    end
  end

  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      // NOTE: sequential state uses non-blocking assignments. Every register
      // then samples pre-edge values, whatever order the statements are in.
      r_v1   <= 1'b0;
      r_a1   <= '0;
      r_neg1 <= '0;
      r_one1 <= '0;
      r_two1 <= '0;
      r_tag1 <= '0;
      r_v2   <= 1'b0;
      // NOTE: data arrays are normally left unreset. This one is cleared
      // because the outputs must read as zero after reset.
      r_pp2  <= '0;
      r_tag2 <= '0;
    end else begin
      if (Flush_SI)       r_v1 <= 1'b0;
      else if (w_s1_load) r_v1 <= 1'b1;
      else if (w_s2_load) r_v1 <= 1'b0;

      if (w_s1_load) begin
        r_a1   <= Mant_a_DI;
        r_neg1 <= w_neg;
        r_one1 <= w_one;
        r_two1 <= w_two;
        r_tag1 <= Tag_DI;
      end

      if (Flush_SI)       r_v2 <= 1'b0;
      else if (w_s2_load) r_v2 <= r_v1;

      // Data moves only with a valid operation, so a stalled output never changes.
      if (w_s2_load && r_v1) begin
        r_pp2  <= w_pp;
        r_tag2 <= r_tag1;
      end
    end
  end

  assign Valid_SO    = r_v2;
  assign Pp_index_DO = r_pp2;
  assign Tag_DO      = r_tag2;

endmodule

// File: tb/tb_booth_pp_gen.sv
// -----------------------------------------------------------------------------
// tb_booth_pp_gen
//
// Self-checking bench for booth_pp_gen.
// A negedge monitor keeps a scoreboard queue. When an input is accepted, it
// pushes the expected products and tag, computed from an arithmetic digit
// model. It pops and compares on every output transfer.
// A table of directed operand pairs checks the sum invariant. Hand-written
// sequences cover latency, stalls, flush and reset.
// -----------------------------------------------------------------------------
module tb_booth_pp_gen;
  import fpu_defs_fmac::*;

  localparam int TW   = 4;
  localparam int NDIG = 13;
  localparam int MW   = C_MANT + 1;
  localparam int PPW  = 2 * C_MANT + 3;

  typedef logic [NDIG-1:0][PPW-1:0] pp_t;

  typedef struct {
    pp_t           pp;
    logic [TW-1:0] tag;
  } exp_t;

  typedef struct {
    logic [MW-1:0]  a;
    logic [MW-1:0]  b;
    logic [TW-1:0]  tag;
    logic [PPW-1:0] sum;
  } vec_t;

  logic          clk;
  logic          rst;
  logic          flush;
  logic          valid_i;
  logic          ready_o;
  logic [MW-1:0] a, b;
  logic [TW-1:0] tag_i;
  logic          valid_o;
  logic          ready_i;
  pp_t           pp_o;
  logic [TW-1:0] tag_o;

  booth_pp_gen #(.TAG_WIDTH(TW)) dut (
    .Clk_CI      (clk),
    .Rst_RI      (rst),
    .Flush_SI    (flush),
    .Valid_SI    (valid_i),
    .Ready_SO    (ready_o),
    .Mant_a_DI   (a),
    .Mant_b_DI   (b),
    .Tag_DI      (tag_i),
    .Valid_SO    (valid_o),
    .Ready_SI    (ready_i),
    .Pp_index_DO (pp_o),
    .Tag_DO      (tag_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [1023:0] act, input logic [1023:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Digit value d = -2*b[2i+1] + b[2i] + b[2i-1]; product = d*A*4^i mod 2^PPW.
  function automatic pp_t model_pp(input logic [MW-1:0] ma, input logic [MW-1:0] mb);
    pp_t        r;
    logic [26:0] bx;
    int         d;
    longint     v;
    r  = '0;
    bx = '0;
    bx[MW:1] = mb;
    for (int i = 0; i < NDIG; i++) begin
      d = -2 * int'(bx[2*i+2]) + int'(bx[2*i+1]) + int'(bx[2*i]);
      v = longint'(d) * longint'(ma) * (longint'(1) <<< (2 * i));
      r[i] = v[PPW-1:0];
    end
    return r;
  endfunction

  function automatic logic [PPW-1:0] pp_sum(input pp_t p);
    logic [PPW-1:0] s;
    s = '0;
    for (int i = 0; i < NDIG; i++) s = s + p[i];
    return s;
  endfunction

  // Scoreboard monitor
  exp_t sb[$];
  exp_t m_e;
  int   n_out = 0;
  int   cyc = 0, cyc_first = 0, cyc_last = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid_o && ready_i && !rst) begin
      if (sb.size() == 0) begin
        check("spurious_output", valid_o, 1'b0);
      end else begin
        m_e = sb.pop_front();
        check("sb_pp", pp_o, m_e.pp);
        check("sb_tag", tag_o, m_e.tag);
        if (n_out == 0) cyc_first = cyc;
        cyc_last = cyc;
        n_out++;
      end
    end
    if (rst || flush) sb.delete();
    else if (valid_i && ready_o) sb.push_back('{model_pp(a, b), tag_i});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t           vt[8];
  pp_t            e_pp;
  pp_t            hold_pp;
  logic [TW-1:0]  hold_tag;
  int             lows, k, base;
  logic [TW-1:0]  nt;

  initial begin
    rst = 1'b1; flush = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
    a = '0; b = '0; tag_i = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("reset_valid", valid_o, 1'b0);
    check("reset_pp", pp_o, '0);
    check("reset_tag", tag_o, '0);
    check("reset_ready", ready_o, 1'b1);

    // A=1, B=3, tag 5: results two cycles later
    a = MW'(1); b = MW'(3); tag_i = 4'd5; valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    check("lat1_valid", valid_o, 1'b0);
    tick();
    check("lat2_valid", valid_o, 1'b1);
    check("lat2_tag", tag_o, 4'd5);
    e_pp = '0;
    e_pp[0] = 49'h1FFFFFFFFFFFF;
    e_pp[1] = 49'h4;
    check("pp_1x3", pp_o, e_pp);
    tick();

    // Directed operand table: sum invariant and zero cases
    vt[0] = '{24'hFFFFFF, 24'hFFFFFF, 4'h1, 49'h0FFFFFE000001};
    vt[1] = '{24'h800000, 24'h800000, 4'h2, 49'h0400000000000};
    vt[2] = '{24'h000000, 24'h123456, 4'h3, 49'h0};
    vt[3] = '{24'hABCDEF, 24'h000000, 4'h4, 49'h0};
    vt[4] = '{24'h000001, 24'h000003, 4'h5, 49'h3};
    vt[5] = '{24'hFFFFFF, 24'h000001, 4'h6, 49'h0000000FFFFFF};
    vt[6] = '{24'h000001, 24'hFFFFFF, 4'h7, 49'h0000000FFFFFF};
    vt[7] = '{24'h800000, 24'hFFFFFF, 4'h8, 49'h07FFFFF800000};
    for (int i = 0; i < 8; i++) begin
      a = vt[i].a; b = vt[i].b; tag_i = vt[i].tag; valid_i = 1'b1;
      tick();
      valid_i = 1'b0;
      tick();
      check($sformatf("vec%0d_valid", i), valid_o, 1'b1);
      check($sformatf("vec%0d_tag", i), tag_o, vt[i].tag);
      check($sformatf("vec%0d_sum", i), pp_sum(pp_o), vt[i].sum);
      if (vt[i].a == '0 || vt[i].b == '0)
        check($sformatf("vec%0d_allzero", i), pp_o, '0);
      tick();
    end

    // 1000 random back-to-back operations at full throughput
    n_out = 0; lows = 0;
    for (int i = 0; i < 1000; i++) begin
      a = MW'($urandom); b = MW'($urandom); tag_i = TW'(i); valid_i = 1'b1;
      if (!ready_o) lows++;
      tick();
    end
    valid_i = 1'b0;
    repeat (4) tick();
    check("rand_ready_lows", lows, 0);
    check("rand_count", n_out, 1000);
    check("rand_throughput", cyc_last - cyc_first, 999);
    check("rand_sb_empty", sb.size(), 0);

    // Back-pressure: Ready_SI low for 5 cycles with Valid_SI held high
    ready_i = 1'b0; n_out = 0; k = 0; nt = 4'd1;
    a = MW'($urandom); b = MW'($urandom); tag_i = nt; valid_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp_ready_c%0d", c), ready_o, (k < 2));
      if (c == 2) begin
        check("bp_valid_first", valid_o, 1'b1);
        hold_pp = pp_o; hold_tag = tag_o;
      end else if (c > 2) begin
        check($sformatf("bp_valid_c%0d", c), valid_o, 1'b1);
        check($sformatf("bp_pp_stable_c%0d", c), pp_o, hold_pp);
        check($sformatf("bp_tag_stable_c%0d", c), tag_o, hold_tag);
      end
      if (ready_o) begin
        k++;
        nt = nt + 4'd1;
        tick();
        a = MW'($urandom); b = MW'($urandom); tag_i = nt;
      end else begin
        tick();
      end
    end
    check("bp_accepted", k, 2);
    valid_i = 1'b0; ready_i = 1'b1;
    repeat (4) tick();
    check("bp_drain_count", n_out, 2);
    check("bp_sb_empty", sb.size(), 0);

    // Flush with both stages full and a coincident input
    ready_i = 1'b0; n_out = 0;
    a = MW'($urandom); b = MW'($urandom); tag_i = 4'd6; valid_i = 1'b1;
    tick();
    a = MW'($urandom); b = MW'($urandom); tag_i = 4'd7;
    tick();
    a = MW'($urandom); b = MW'($urandom); tag_i = 4'd8; flush = 1'b1;
    check("flush_ready", ready_o, 1'b0);
    tick();
    flush = 1'b0; valid_i = 1'b0;
    check("flush_valid", valid_o, 1'b0);
    ready_i = 1'b1;
    repeat (3) tick();
    check("flush_no_output", n_out, 0);
    a = MW'($urandom); b = MW'($urandom); tag_i = 4'd9; valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    repeat (3) tick();
    check("flush_after_count", n_out, 1);
    check("flush_sb_empty", sb.size(), 0);

    // Reset asserted for one cycle mid-stream
    ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = MW'($urandom); b = MW'($urandom); tag_i = TW'(i + 10); valid_i = 1'b1;
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0; valid_i = 1'b0;
    check("rst2_valid", valid_o, 1'b0);
    check("rst2_pp", pp_o, '0);
    check("rst2_tag", tag_o, '0);
    check("rst2_ready", ready_o, 1'b1);
    base = n_out;
    repeat (4) tick();
    check("rst2_no_stale", n_out - base, 0);
    a = 24'hFFFFFF; b = 24'h800001; tag_i = 4'd15; valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    repeat (3) tick();
    check("rst2_after_count", n_out - base, 1);
    check("rst2_sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
